// File: rtl/cla16_pipe.sv
// Two-stage pipelined 16-bit adder built from four 4-bit carry look-ahead slices.
// Stage 1 adds the low byte and registers the carry c8 with the high operand bytes;
// stage 2 adds the high byte and registers sum/cout/ovf. Valid/ready on both sides.
module cla16_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned HALF = WIDTH / 2;

    // One 4-bit carry look-ahead slice: returns {carry_out, sum}.
    function automatic logic [SLICE:0] cla4(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             ci
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    // Stage-1 registers
    logic            s1_valid;
    logic [HALF-1:0] lo_sum;
    logic            c8;
    logic [HALF-1:0] a_hi;
    logic [HALF-1:0] b_hi;

    // Slice results
    logic [SLICE:0]  slice0_c;
    logic [SLICE:0]  slice1_c;
    logic [SLICE:0]  slice2_c;
    logic [SLICE:0]  slice3_c;
    logic [HALF-1:0] lo_sum_c;
    logic [HALF-1:0] hi_sum_c;
    logic            c8_c;
    logic            c15_c;
    logic            c16_c;

    // Handshake terms
    logic            s2_ready;
    logic            in_fire;
    logic            s1_adv;

    // Low byte: two slices chained on the incoming operands.
    always_comb begin
        slice0_c = cla4(a[SLICE-1:0], b[SLICE-1:0], cin);
        slice1_c = cla4(a[HALF-1:SLICE], b[HALF-1:SLICE], slice0_c[SLICE]);
        lo_sum_c = {slice1_c[SLICE-1:0], slice0_c[SLICE-1:0]};
        c8_c     = slice1_c[SLICE];
    end

    // High byte: two slices chained on the stage-1 registers; c15 recovered from sum bit 15.
    always_comb begin
        slice2_c = cla4(a_hi[SLICE-1:0], b_hi[SLICE-1:0], c8);
        slice3_c = cla4(a_hi[HALF-1:SLICE], b_hi[HALF-1:SLICE], slice2_c[SLICE]);
        hi_sum_c = {slice3_c[SLICE-1:0], slice2_c[SLICE-1:0]};
        c16_c    = slice3_c[SLICE];
        c15_c    = hi_sum_c[HALF-1] ^ a_hi[HALF-1] ^ b_hi[HALF-1];
    end

    // Ready chain: combinational from out_ready back to in_ready only.
    always_comb begin
        s2_ready = !out_valid || out_ready;
        in_ready = !s1_valid || s2_ready;
        in_fire  = in_valid && in_ready;
        s1_adv   = s1_valid && s2_ready;
    end

    // Stage 1: capture low-byte result and high operand bytes on an input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            lo_sum   <= '0;
            c8       <= 1'b0;
            a_hi     <= '0;
            b_hi     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            lo_sum   <= lo_sum_c;
            c8       <= c8_c;
            a_hi     <= a[WIDTH-1:HALF];
            b_hi     <= b[WIDTH-1:HALF];
        end else if (s2_ready) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: load the full result when stage 1 advances, drop valid when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            sum       <= {hi_sum_c, lo_sum};
            cout      <= c16_c;
            ovf       <= c15_c ^ c16_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla16_pipe.sv
// Directed bench for cla16_pipe: vector table for arithmetic, streamed sequences for
// throughput/backpressure, and a reset-with-ops-in-flight sequence.
module tb_cla16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    cla16_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {signed overflow, carry, sum} from plain integer addition.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [16:0] t;
        logic        v;
        t = 17'({1'b0, x}) + 17'({1'b0, y}) + 17'(ci);
        v = (x[15] == y[15]) && (t[15] != x[15]);
        return {v, t};
    endfunction

    // Stream n ops; out_ready held low for the first stall cycles.
    task automatic run_stream(input string tag, input int n, input int stall);
        logic [17:0] expq[$];
        logic [17:0] e;
        logic [15:0] held_sum;
        logic        held;
        int sent;
        int got;
        int cyc;
        int first_in;
        int first_out;
        int last_out;
        sent = 0; got = 0; cyc = 0; held = 1'b0; held_sum = '0;
        first_in = -1; first_out = -1; last_out = -1;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            in_valid  = (sent < n);
            a         = 16'(32'h9E37 * (sent + 3));
            b         = 16'(32'h7F4B * (sent + 1));
            cin       = sent[0];
            #1;
            if (stall > 0 && cyc >= 2 && cyc < stall) begin
                check({tag, " in_ready during stall"}, 32'(in_ready), 32'd0);
                check({tag, " accepts during stall"}, 32'(sent), 32'd2);
                check({tag, " out_valid during stall"}, 32'(out_valid), 32'd1);
                if (!held) begin
                    held_sum = sum;
                    held     = 1'b1;
                end else begin
                    check({tag, " sum stable"}, 32'(sum), 32'(held_sum));
                end
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check({tag, " unexpected result"}, 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check({tag, " sum"}, 32'(sum), 32'(e[15:0]));
                    check({tag, " cout"}, 32'(cout), 32'(e[16]));
                    check({tag, " ovf"}, 32'(ovf), 32'(e[17]));
                end
                got++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, cin));
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            cyc++;
        end
        check({tag, " results received"}, 32'(got), 32'(n));
        check({tag, " consecutive results"}, 32'(last_out - first_out), 32'(n - 1));
        if (stall == 0) check({tag, " latency"}, 32'(first_out - first_in), 32'd2);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check({tag, " no duplicate"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single ops: check 2-cycle latency and result.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            #1 check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
            #1 check($sformatf("vec%0d early valid", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].cout));
            check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
        end

        run_stream("b2b", 4, 0);
        run_stream("stall", 6, 5);

        // Reset with two ops buffered.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(negedge clk);
        a = 16'h3333; b = 16'h4444;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset sum", 32'(sum), 32'd0);
        check("async reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1 check("post-reset in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 16'(i * 16'h5A5A); b = 16'hFFFF; cin = 1'b1;
            #1 check("no stale result", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
